// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the stopwatch: turns button pulses and the slow tick
// into decrement enable, preset load, lap freeze and end-of-count blink.
module stopwatch_ctrl #(
    parameter int BLINK_TICKS = 6,
    parameter int BLINK_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    input  logic       tick,
    input  logic       cnt_zero,
    output logic       count_en,
    output logic       load,
    output logic       lap_hold,
    output logic       done,
    output logic       blink,
    output logic [2:0] state
);

    // Interface: start_stop, lap_reset and tick are single-cycle pulses with no
    // back-pressure; a pulse is consumed in the cycle it is high or dropped.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             st, nx;
    logic [BLINK_W-1:0] bcnt, bcnt_nx;
    logic               blink_q, blink_nx;
    logic               load_q, load_nx;
    logic               lap_hold_q, done_q;
    logic               want_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            bcnt       <= '0;
            blink_q    <= 1'b0;
            load_q     <= 1'b0;
            lap_hold_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            st         <= nx;
            bcnt       <= bcnt_nx;
            blink_q    <= blink_nx;
            load_q     <= load_nx;
            lap_hold_q <= (nx == S_LAP);
            done_q     <= (nx == S_DONE);
        end
    end

    // Blink counter and toggle hold their value only while staying in DONE;
    // every other path (including entry into DONE) clears them.
    always_comb begin
        nx        = st;
        want_load = 1'b0;
        bcnt_nx   = '0;
        blink_nx  = 1'b0;
        case (st)
            S_IDLE: begin
                if (lap_reset || (start_stop && cnt_zero)) begin
                    want_load = 1'b1;
                end else if (start_stop) begin
                    nx = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_zero)       nx = S_DONE;
                else if (lap_reset) nx = S_LAP;
                else if (start_stop) nx = S_PAUSE;
            end
            S_LAP: begin
                if (cnt_zero)       nx = S_DONE;
                else if (lap_reset) nx = S_RUN;
                else if (start_stop) nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (lap_reset) begin
                    nx        = S_IDLE;
                    want_load = 1'b1;
                end else if (start_stop) begin
                    nx = S_RUN;
                end
            end
            S_DONE: begin
                bcnt_nx  = bcnt;
                blink_nx = blink_q;
                if (start_stop || lap_reset) begin
                    nx        = S_IDLE;
                    want_load = 1'b1;
                    bcnt_nx   = '0;
                    blink_nx  = 1'b0;
                end else if (tick) begin
                    if (bcnt == BLINK_W'(BLINK_TICKS - 1)) begin
                        nx        = S_IDLE;
                        want_load = 1'b1;
                        bcnt_nx   = '0;
                        blink_nx  = 1'b0;
                    end else begin
                        bcnt_nx  = bcnt + BLINK_W'(1);
                        blink_nx = ~blink_q;
                    end
                end
            end
            default: nx = S_IDLE;
        endcase
        // A second reload request on the cycle right after a load is suppressed.
        load_nx = want_load & ~load_q;
    end

    assign count_en = tick & ((st == S_RUN) | (st == S_LAP)) & ~cnt_zero;
    assign load     = load_q;
    assign lap_hold = lap_hold_q;
    assign done     = done_q;
    assign blink    = blink_q;
    assign state    = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: each scenario pushes the expected
// {state,load,lap_hold,done,blink,count_en} per cycle and compares against the DUT.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst, start_stop, lap_reset, tick, cnt_zero;
    logic       count_en, load, lap_hold, done, blink;
    logic [2:0] state;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    stopwatch_ctrl #(.BLINK_TICKS(6), .BLINK_W(4)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .lap_reset(lap_reset),
        .tick(tick), .cnt_zero(cnt_zero), .count_en(count_en), .load(load),
        .lap_hold(lap_hold), .done(done), .blink(blink), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ev(input int st, input bit ld, input bit lh,
                                      input bit dn, input bit bl, input bit ce);
        logic [2:0] s3;
        s3 = 3'(st);
        return {s3, ld, lh, dn, bl, ce};
    endfunction

    // Entered at posedge+1: drives one cycle, samples count_en mid-cycle and the
    // registered outputs just after the next rising edge.
    task automatic step(input logic r, input logic ss, input logic lr,
                        input logic tk, input logic cz, input logic [7:0] e);
        logic ce_s;
        rst = r; start_stop = ss; lap_reset = lr; tick = tk; cnt_zero = cz;
        exp_q.push_back(e);
        #4;
        ce_s = count_en;
        @(posedge clk);
        #1;
        obs_q.push_back({state, load, lap_hold, done, blink, ce_s});
        start_stop = 1'b0; lap_reset = 1'b0; tick = 1'b0;
    endtask

    task automatic idle_gap(input logic cz, input logic [7:0] e);
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, cz, e);
    endtask

    task automatic test_reset;
        int idx = 0;
        logic [7:0] e_v, o_v;
        step(1, 1, 0, 1, 0, ev(0, 0, 0, 0, 0, 0));
        step(1, 0, 1, 1, 1, ev(0, 0, 0, 0, 0, 0));
        step(1, 1, 1, 0, 0, ev(0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_reset[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_run;
        int idx = 0;
        logic [7:0] e_v, o_v;
        step(0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            idle_gap(1'b0, ev(1, 0, 0, 0, 0, 0));
            step(0, 0, 0, 1, 0, ev(1, 0, 0, 0, 0, 1));
        end
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_run[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_lap;
        int idx = 0;
        logic [7:0] e_v, o_v;
        step(0, 0, 1, 0, 0, ev(3, 0, 1, 0, 0, 0));
        step(0, 0, 0, 1, 0, ev(3, 0, 1, 0, 0, 1));
        idle_gap(1'b0, ev(3, 0, 1, 0, 0, 0));
        step(0, 0, 0, 1, 0, ev(3, 0, 1, 0, 0, 1));
        step(0, 0, 1, 0, 0, ev(1, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_lap[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_done;
        int idx = 0;
        logic [7:0] e_v, o_v;
        bit bl = 1'b0;
        // cnt_zero beats start_stop and suppresses the tick's count_en
        step(0, 1, 0, 1, 1, ev(4, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            idle_gap(1'b1, ev(4, 0, 0, 1, bl, 0));
            bl = ~bl;
            step(0, 0, 0, 1, 1, ev(4, 0, 0, 1, bl, 0));
        end
        step(0, 0, 0, 1, 1, ev(0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_done[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_pause;
        int idx = 0;
        logic [7:0] e_v, o_v;
        step(0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, ev(2, 0, 0, 0, 0, 0));
        step(0, 0, 0, 1, 0, ev(2, 0, 0, 0, 0, 0));
        step(0, 1, 1, 0, 0, ev(0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_pause[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_lap_reset;
        int idx = 0;
        logic [7:0] e_v, o_v;
        step(0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, ev(3, 0, 1, 0, 0, 0));
        step(1, 1, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_lap_reset[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        logic [7:0] e_v, o_v;
        bit bl = 1'b0;
        step(0, 1, 0, 0, 1, ev(0, 1, 0, 0, 0, 0));   // start at zero reloads
        step(0, 0, 1, 0, 1, ev(0, 0, 0, 0, 0, 0));   // no load twice in a row
        step(0, 0, 1, 0, 1, ev(0, 1, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0));
        step(0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 0, 0, ev(3, 0, 1, 0, 0, 0));
        step(0, 0, 1, 1, 1, ev(4, 0, 0, 1, 0, 0));   // zero beats lap_reset in LAP
        for (int k = 0; k < 3; k++) begin
            bl = ~bl;
            step(0, 0, 0, 1, 1, ev(4, 0, 0, 1, bl, 0));
        end
        step(0, 1, 0, 0, 1, ev(0, 1, 0, 0, 0, 0));   // button exits DONE early
        step(0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 1, ev(4, 0, 0, 1, 0, 0));
        bl = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bl = ~bl;
            step(0, 0, 0, 1, 1, ev(4, 0, 0, 1, bl, 0));
        end
        step(0, 0, 0, 1, 1, ev(0, 1, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e_v = exp_q.pop_front(); o_v = obs_q.pop_front(); n_checks++;
            if (o_v !== e_v) begin
                n_errors++;
                $display("FAIL test_back_to_back[%0d] got=%b exp=%b (st,ld,lh,dn,bl,ce)", idx, o_v, e_v);
            end
            idx++;
        end
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; lap_reset = 1'b0; tick = 1'b0; cnt_zero = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_run();
        test_lap();
        test_done();
        test_pause();
        test_lap_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
